pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer_pkg.sv | 13 +
 rtl/jump_target_calc.sv | 10 +
 rtl/pc_sequencer.sv | 103 ++++++++++
 tb/tb_pc_sequencer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_sequencer_pkg.sv
// rtl/pc_sequencer_pkg.sv - shared types and constants for the PC sequencer
package pc_sequencer_pkg;
  localparam int PC_W  = 32;
  localparam int IDX_W = 26;
  localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_OUT
  } state_t;
endpackage

// File: rtl/jump_target_calc.sv
// rtl/jump_target_calc.sv - J-type target: region bits of pc+4 with word index
module jump_target_calc
  import pc_sequencer_pkg::*;
(
  input  logic [IDX_W-1:0] jump_idx,
  input  logic [PC_W-1:0]  pc_plus4,
  output logic [PC_W-1:0]  target
);
  assign target = {pc_plus4[PC_W-1:PC_W-4], jump_idx, 2'b00};
endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - single-outstanding fetch FSM, PC register and redirect mux
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  output logic              inst_valid,
  output logic [31:0]       inst_out,
  output logic [PC_W-1:0]   inst_pc,
  input  logic              inst_ready,
  input  logic              jr,
  input  logic [PC_W-1:0]   jr_addr,
  input  logic              jump,
  input  logic [IDX_W-1:0]  jump_idx,
  input  logic              branch,
  input  logic [15:0]       branch_off,
  output logic              misalign
);
  state_t          state, state_next;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_plus4;
  logic [PC_W-1:0] jump_tgt;
  logic [PC_W-1:0] branch_tgt;
  logic [PC_W-1:0] next_pc;
  logic            accept;

  assign accept     = (state == S_OUT) && inst_ready;
  assign imem_addr  = pc;
  assign pc_plus4   = inst_pc + 32'd4;
  assign branch_tgt = pc_plus4 + {{14{branch_off[15]}}, branch_off, 2'b00};

  jump_target_calc u_jump_target_calc (
    .jump_idx (jump_idx),
    .pc_plus4 (pc_plus4),
    .target   (jump_tgt)
  );

  // Redirects are relative to the held instruction; jr wins over all others.
  always_comb begin
    next_pc = pc_plus4;
    if (jr)
      next_pc = {jr_addr[PC_W-1:2], 2'b00};
    else if (jump)
      next_pc = jump_tgt;
    else if (branch)
      next_pc = branch_tgt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= S_IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    imem_req   = 1'b0;
    inst_valid = 1'b0;
    case (state)
      S_IDLE: state_next = S_REQ;
      S_REQ: begin
        imem_req = 1'b1;
        if (imem_gnt)
          state_next = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid)
          state_next = S_OUT;
      end
      S_OUT: begin
        inst_valid = 1'b1;
        if (inst_ready)
          state_next = S_REQ;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      inst_out <= '0;
      inst_pc  <= '0;
      misalign <= 1'b0;
    end else begin
      misalign <= accept && jr && (jr_addr[1:0] != 2'b00);
      if (state == S_WAIT && imem_rvalid) begin
        inst_out <= imem_rdata;
        inst_pc  <= pc;
      end
      if (accept)
        pc <= next_pc;
    end
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed and randomized checks against a fetch-level model
module tb_pc_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        inst_valid;
  logic [31:0] inst_out;
  logic [31:0] inst_pc;
  logic        inst_ready = 1'b0;
  logic        jr = 1'b0;
  logic [31:0] jr_addr = '0;
  logic        jump = 1'b0;
  logic [25:0] jump_idx = '0;
  logic        branch = 1'b0;
  logic [15:0] branch_off = '0;
  logic        misalign;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_pc;
  logic [31:0] cur_pc;
  logic [31:0] cur_word;

  pc_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst_out(inst_out), .inst_pc(inst_pc),
    .inst_ready(inst_ready), .jr(jr), .jr_addr(jr_addr), .jump(jump),
    .jump_idx(jump_idx), .branch(branch), .branch_off(branch_off),
    .misalign(misalign)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Architectural next-PC rule, computed with plain arithmetic.
  function automatic logic [31:0] model_next(input logic [31:0] ipc, input bit j_r,
      input logic [31:0] ja, input bit j, input logic [25:0] idx, input bit b,
      input logic [15:0] off);
    logic [31:0] seq;
    int signed   s;
    seq = ipc + 32'd4;
    if (j_r) return ja - (ja % 32'd4);
    if (j) return (seq & 32'hF000_0000) + 32'(idx) * 32'd4;
    if (b) begin
      s = $signed(off);
      return seq + 32'(s * 4);
    end
    return seq;
  endfunction

  task automatic clear_redirects();
    jr = 1'b0; jump = 1'b0; branch = 1'b0;
    jr_addr = '0; jump_idx = '0; branch_off = '0;
  endtask

  task automatic do_fetch(input int gdly, input int rdly, input int hold);
    logic [31:0] word;
    int n;
    n = 0;
    while (!imem_req && n < 8) begin
      step();
      n++;
    end
    check("req_seen", {31'd0, imem_req}, 32'd1);
    check("fetch_addr", imem_addr, exp_pc);
    for (int i = 0; i < gdly; i++) begin
      imem_gnt = 1'b0;
      imem_rvalid = 1'($urandom_range(0, 1));
      step();
      check("req_held", {31'd0, imem_req}, 32'd1);
      check("addr_stable", imem_addr, exp_pc);
    end
    imem_gnt = 1'b1;
    imem_rvalid = 1'b0;
    step();
    imem_gnt = 1'b0;
    check("req_drop_after_gnt", {31'd0, imem_req}, 32'd0);
    for (int i = 0; i < rdly; i++) begin
      imem_gnt = 1'($urandom_range(0, 1));
      step();
      check("wait_no_valid", {31'd0, inst_valid}, 32'd0);
    end
    imem_gnt = 1'b0;
    word = $urandom;
    imem_rdata = word;
    imem_rvalid = 1'b1;
    step();
    imem_rvalid = 1'b0;
    imem_rdata = $urandom;
    check("inst_valid", {31'd0, inst_valid}, 32'd1);
    check("inst_out", inst_out, word);
    check("inst_pc", inst_pc, exp_pc);
    cur_pc = exp_pc;
    cur_word = word;
    for (int i = 0; i < hold; i++) begin
      inst_ready = 1'b0;
      jr = 1'($urandom_range(0, 1));
      jr_addr = $urandom;
      jump = 1'($urandom_range(0, 1));
      branch = 1'($urandom_range(0, 1));
      imem_gnt = 1'($urandom_range(0, 1));
      imem_rvalid = 1'($urandom_range(0, 1));
      step();
      check("hold_valid", {31'd0, inst_valid}, 32'd1);
      check("hold_out", inst_out, cur_word);
      check("hold_pc", inst_pc, cur_pc);
      check("hold_no_req", {31'd0, imem_req}, 32'd0);
      check("hold_misalign", {31'd0, misalign}, 32'd0);
    end
    imem_gnt = 1'b0;
    imem_rvalid = 1'b0;
    clear_redirects();
  endtask

  task automatic do_accept(input bit j_r, input logic [31:0] ja, input bit j,
      input logic [25:0] idx, input bit b, input logic [15:0] off);
    jr = j_r; jr_addr = ja; jump = j; jump_idx = idx; branch = b; branch_off = off;
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    clear_redirects();
    exp_pc = model_next(cur_pc, j_r, ja, j, idx, b, off);
    check("accept_req", {31'd0, imem_req}, 32'd1);
    check("accept_valid_drop", {31'd0, inst_valid}, 32'd0);
    check("next_addr", imem_addr, exp_pc);
    check("misalign_pulse", {31'd0, misalign}, {31'd0, (j_r && (ja % 32'd4) != 0)});
    step();
    check("misalign_clear", {31'd0, misalign}, 32'd0);
    check("req_waiting_gnt", {31'd0, imem_req}, 32'd1);
  endtask

  initial begin
    int          req_cyc[$];
    logic [31:0] req_addr[$];

    exp_pc = 32'h0;
    cur_pc = 32'h0;
    cur_word = 32'h0;
    step();
    step();
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_valid", {31'd0, inst_valid}, 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_inst_out", inst_out, 32'h0);
    check("rst_inst_pc", inst_pc, 32'h0);
    check("rst_misalign", {31'd0, misalign}, 32'd0);
    rst_n = 1'b1;

    // Back-to-back sequential fetches with an always-ready memory and decoder.
    imem_gnt = 1'b1; imem_rvalid = 1'b1; inst_ready = 1'b1; imem_rdata = $urandom;
    for (int c = 0; c < 9; c++) begin
      step();
      if (imem_req) begin
        req_cyc.push_back(c);
        req_addr.push_back(imem_addr);
      end
    end
    imem_gnt = 1'b0; imem_rvalid = 1'b0; inst_ready = 1'b0;
    check("seq_req_count", 32'(req_cyc.size()), 32'd3);
    if (req_cyc.size() == 3) begin
      check("seq_addr0", req_addr[0], 32'h0);
      check("seq_addr1", req_addr[1], 32'h4);
      check("seq_addr2", req_addr[2], 32'h8);
      check("seq_gap01", 32'(req_cyc[1] - req_cyc[0]), 32'd3);
      check("seq_gap12", 32'(req_cyc[2] - req_cyc[1]), 32'd3);
    end
    check("seq_valid", {31'd0, inst_valid}, 32'd1);
    check("seq_inst_pc", inst_pc, 32'h8);
    cur_pc = 32'h8;
    cur_word = inst_out;
    do_accept(0, 0, 0, 0, 0, 0);

    do_fetch(0, 0, 0);
    do_accept(1, 32'h4000_0010, 0, 0, 0, 0);
    do_fetch(1, 1, 0);
    do_accept(0, 0, 1, 26'h0000100, 0, 0);
    check("jump_target", imem_addr, 32'h4000_0400);
    do_fetch(0, 2, 1);
    do_accept(1, 32'h0000_0100, 0, 0, 0, 0);
    do_fetch(0, 0, 0);
    do_accept(0, 0, 0, 0, 1, 16'hFFFE);
    check("branch_back", imem_addr, 32'h0000_00FC);
    do_fetch(0, 0, 0);
    do_accept(1, 32'h0000_0100, 0, 0, 0, 0);
    do_fetch(0, 0, 0);
    do_accept(0, 0, 0, 0, 1, 16'h0003);
    check("branch_fwd", imem_addr, 32'h0000_0110);
    do_fetch(0, 0, 0);
    do_accept(1, 32'h0000_1003, 1, 26'h3FF_FFFF, 1, 16'h0010);
    check("jr_priority", imem_addr, 32'h0000_1000);
    do_fetch(4, 0, 5);
    do_accept(0, 0, 0, 0, 0, 0);
    do_fetch(0, 0, 0);
    do_accept(1, 32'hFFFF_FFFC, 0, 0, 0, 0);
    do_fetch(0, 0, 0);
    do_accept(0, 0, 0, 0, 0, 0);
    check("seq_wrap", imem_addr, 32'h0);

    for (int k = 0; k < 25; k++) begin
      do_fetch($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
      do_accept(($urandom_range(0, 3) == 0), $urandom, ($urandom_range(0, 3) == 0),
                26'($urandom), ($urandom_range(0, 2) == 0), 16'($urandom));
    end

    // Reset while a fetch is outstanding; the late response must be dropped.
    imem_gnt = 1'b1;
    step();
    imem_gnt = 1'b0;
    check("pre_rst_wait", {31'd0, imem_req}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("async_rst_addr", imem_addr, 32'h0);
    check("async_rst_req", {31'd0, imem_req}, 32'd0);
    check("async_rst_pc", inst_pc, 32'h0);
    step();
    rst_n = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      step();
      check("late_rvalid_req", {31'd0, imem_req}, 32'd1);
      check("late_rvalid_addr", imem_addr, 32'h0);
      check("late_rvalid_valid", {31'd0, inst_valid}, 32'd0);
    end
    imem_rvalid = 1'b0;
    exp_pc = 32'h0;
    do_fetch(1, 1, 0);
    do_accept(0, 0, 0, 0, 0, 0);
    check("restart_next", imem_addr, 32'h4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
